// File: rtl/golden_vector_checker.sv
// Purpose: compares one DUT output sample per cycle against a packed golden table, drives the vector index, counts mismatches; optional MISR via GOLDEN_CHECKER_SIG_EN.
// Latency: err_count/first_err_idx update on the edge that samples a vector; done/pass assert on the edge that samples the last vector.
// Backpressure: i_in_valid low stalls the run indefinitely with all state held; no ready is returned upstream.
module golden_vector_checker #(
    parameter int                     WIDTH    = 1,
    parameter int                     DEPTH    = 4,
    parameter int                     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [DEPTH*WIDTH-1:0] EXPECTED = 4'b0111
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_dut_out,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [IDX_W:0]   o_err_count,
    output logic [IDX_W-1:0] o_first_err_idx
`ifdef GOLDEN_CHECKER_SIG_EN
    ,
    output logic [15:0]      o_sig
`endif
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [IDX_W:0]   ERR_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_first_err_idx;
    logic [IDX_W:0]   r_err_count;
    logic             r_done;
    logic             r_pass;

    logic [WIDTH-1:0] w_exp;
    logic             w_start_ok;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_last;
    logic [IDX_W:0]   w_err_next;

    assign w_exp      = EXPECTED[int'(r_idx)*WIDTH +: WIDTH];
    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept   = (r_state == S_RUN) && i_in_valid;
    // Case inequality so that X/Z on the DUT response is reported as a miscompare.
    assign w_mismatch = (i_dut_out !== w_exp);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_err_next = (w_accept && w_mismatch && (r_err_count != ERR_MAX))
                        ? r_err_count + 1'b1 : r_err_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state         <= S_RUN;
                        r_idx           <= '0;
                        r_err_count     <= '0;
                        r_first_err_idx <= '0;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_in_valid) begin
                        r_err_count <= w_err_next;
                        if (w_mismatch && (r_err_count == '0)) begin
                            r_first_err_idx <= r_idx;
                        end
                        // The index parks on the last vector; only a new start rewinds it.
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_idx           = r_idx;
    assign o_busy          = (r_state == S_RUN);
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_err_count     = r_err_count;
    assign o_first_err_idx = r_first_err_idx;

`ifdef GOLDEN_CHECKER_SIG_EN
    localparam logic [15:0] SIG_SEED = 16'hFFFF;
    localparam logic [15:0] SIG_POLY = 16'h1021;

    logic [15:0] r_sig;
    logic [15:0] w_sig_in;
    logic [15:0] w_sig_next;

    generate
        if (WIDTH >= 16) begin : g_sig_trunc
            assign w_sig_in = i_dut_out[15:0];
        end else begin : g_sig_zext
            assign w_sig_in = {{(16-WIDTH){1'b0}}, i_dut_out};
        end
    endgenerate

    assign w_sig_next = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? SIG_POLY : 16'h0000) ^ w_sig_in;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_ok) begin
            r_sig <= SIG_SEED;
        end else if (w_accept) begin
            r_sig <= w_sig_next;
        end
    end

    assign o_sig = r_sig;
`else
    // Without the signature option only the compare path exists.
`endif

endmodule

// File: tb/tb_golden_vector_checker.sv
// Directed-vector bench for golden_vector_checker (default table: NAND, 1,1,1,0).
`timescale 1ns/1ps
module tb_golden_vector_checker;

    localparam int WIDTH = 1;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] dut_out = '0;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             done;
    logic             pass;
    logic [IDX_W:0]   err_count;
    logic [IDX_W-1:0] first_err_idx;
`ifdef GOLDEN_CHECKER_SIG_EN
    logic [15:0]      sig;
    logic [15:0]      sig_model;
`endif

    int n_vec = 0;
    int n_err = 0;

    golden_vector_checker #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .EXPECTED (4'b0111)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_in_valid      (in_valid),
        .i_dut_out       (dut_out),
        .o_idx           (idx),
        .o_busy          (busy),
        .o_done          (done),
        .o_pass          (pass),
        .o_err_count     (err_count),
        .o_first_err_idx (first_err_idx)
`ifdef GOLDEN_CHECKER_SIG_EN
        ,
        .o_sig           (sig)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge, outputs are checked at the same point.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

`ifdef GOLDEN_CHECKER_SIG_EN
    // Bit-serial form of x^16+x^12+x^5+1: shift, fold the ejected bit into taps 12/5/0, add data.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
        logic        fb;
        logic [15:0] n;
        fb = s[15];
        n  = s << 1;
        if (fb) begin
            n[12] = ~n[12];
            n[5]  = ~n[5];
            n[0]  = ~n[0];
        end
        n[0] = n[0] ^ d;
        return n;
    endfunction
`endif

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
`ifdef GOLDEN_CHECKER_SIG_EN
        sig_model = 16'hFFFF;
`endif
    endtask

    task automatic sample(input logic v);
        in_valid = 1'b1;
        dut_out  = v;
        cyc();
        in_valid = 1'b0;
`ifdef GOLDEN_CHECKER_SIG_EN
        sig_model = misr_step(sig_model, v);
`endif
    endtask

    task automatic stall(input int n, input int exp_idx);
        for (int k = 0; k < n; k++) begin
            cyc();
            chk("stall_idx", 32'(idx), 32'(exp_idx));
        end
    endtask

    task automatic check_result(input string tag, input int e_pass, input int e_err, input int e_first);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
        chk({tag, "_err"},  32'(err_count), 32'(e_err));
        if (e_err != 0) chk({tag, "_first"}, 32'(first_err_idx), 32'(e_first));
`ifdef GOLDEN_CHECKER_SIG_EN
        chk({tag, "_sig"}, 32'(sig), 32'(sig_model));
`endif
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_idx"},   32'(idx), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_pass"},  32'(pass), 32'd0);
        chk({tag, "_err"},   32'(err_count), 32'd0);
        chk({tag, "_first"}, 32'(first_err_idx), 32'd0);
`ifdef GOLDEN_CHECKER_SIG_EN
        chk({tag, "_sig"}, 32'(sig), 32'hFFFF);
`endif
    endtask

    initial begin
        logic xbit;
        xbit = 1'bx;

        // Reset for two cycles.
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check_reset("rst");

        // in_valid while idle is ignored.
        sample(1'b0);
        chk("idle_valid_err", 32'(err_count), 32'd0);
        chk("idle_valid_busy", 32'(busy), 32'd0);

        // Matching run: idx steps 0,1,2,3, done on the 4th sample edge.
        do_start();
        chk("m_busy", 32'(busy), 32'd1);
        chk("m_idx0", 32'(idx), 32'd0);
        sample(1'b1); chk("m_idx1", 32'(idx), 32'd1); chk("m_nd1", 32'(done), 32'd0);
        sample(1'b1); chk("m_idx2", 32'(idx), 32'd2);
        sample(1'b1); chk("m_idx3", 32'(idx), 32'd3); chk("m_nd3", 32'(done), 32'd0);
        sample(1'b0); chk("m_idx_hold", 32'(idx), 32'd3);
        check_result("match", 1, 0, 0);

        // Samples in DONE leave results and signature frozen.
        in_valid = 1'b1; dut_out = 1'b1;
        cyc(); cyc();
        in_valid = 1'b0;
        check_result("done_frozen", 1, 0, 0);
        chk("done_frozen_idx", 32'(idx), 32'd3);

        // Single mismatch at index 1.
        do_start();
        chk("s_done_clr", 32'(done), 32'd0);
        chk("s_pass_clr", 32'(pass), 32'd0);
        sample(1'b1);
        sample(1'b0); chk("s_err_early", 32'(err_count), 32'd1);
        sample(1'b1);
        sample(1'b0);
        check_result("single", 0, 1, 1);

        // Every vector wrong.
        do_start();
        chk("x_err_clr", 32'(err_count), 32'd0);
        chk("x_first_clr", 32'(first_err_idx), 32'd0);
        sample(1'b0);
        sample(1'b0);
        sample(1'b0);
        sample(1'b1);
        check_result("multi", 0, 4, 0);

        // Three stall cycles after every sample.
        do_start();
        sample(1'b1); stall(3, 1);
        sample(1'b1); stall(3, 2);
        sample(1'b1); stall(3, 3);
        chk("st_not_done", 32'(done), 32'd0);
        sample(1'b0);
        check_result("stall", 1, 0, 0);

        // Start during a run is ignored, then reset abandons the run.
        do_start();
        sample(1'b1);
        sample(1'b1);
        chk("mr_idx2", 32'(idx), 32'd2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("mr_ign_idx", 32'(idx), 32'd2);
        chk("mr_ign_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        in_valid = 1'b1; dut_out = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset("mr_rst");
        cyc(); cyc();
        chk("mr_no_done", 32'(done), 32'd0);
        do_start();
        sample(1'b1);
        sample(1'b1);
        sample(1'b1);
        sample(1'b0);
        check_result("mr_rerun", 1, 0, 0);

        // Restart from DONE with an unknown sample at index 1.
        do_start();
`ifdef GOLDEN_CHECKER_SIG_EN
        chk("rx_sig_seed", 32'(sig), 32'hFFFF);
`endif
        chk("rx_idx0", 32'(idx), 32'd0);
        sample(1'b1);
        sample(xbit);
        sample(1'b1);
        sample(1'b0);
        check_result("restart_x", 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/golden_vector_checker.md
Name: golden_vector_checker

Overview:
- Response-side stage for generated-circuit simulation benches; sits directly downstream of the DUT.
- Consumes one DUT output sample per cycle and compares it against a golden vector table held in a parameter.
- Drives the vector index that the upstream stimulus tables use, counts mismatches and records the first failing index.
- Raises done/pass so the bench can close its log and finish.

Parameters:
- WIDTH, 1, bit width of each DUT output sample.
- DEPTH, 4, number of vectors per run (≥1).
- IDX_W, $clog2(DEPTH) with a minimum of 1, width of the vector index.
- EXPECTED, 4'b0111, packed golden table. Element i occupies bits [i*WIDTH +: WIDTH]. The default is the NAND truth table for the a/b sequence 00,10,01,11.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run. Honoured only in IDLE or DONE.
- in_valid  in  1  dut_out is a valid sample for the current index.
- dut_out  in  WIDTH  DUT response sample.
- idx  out  IDX_W  current vector index, fed to the stimulus tables.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count==0.
- err_count  out  IDX_W+1  saturating mismatch count.
- first_err_idx  out  IDX_W  index of the first mismatch. Valid when err_count!=0.

Behaviour:
- Reset values, applied on a clk edge with rst=1:
  - state=IDLE, idx=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0.
- rst overrides every other input, including a run in progress. The run is abandoned with no done pulse.
- States:
  - IDLE: start → RUN. On that edge, idx, err_count and first_err_idx are cleared.
  - RUN: on each edge with in_valid=1:
    - Compare dut_out against element idx of EXPECTED.
    - On mismatch, increment err_count, saturating at 2^(IDX_W+1)-1.
    - If this is the first mismatch of the run, load first_err_idx with idx.
    - If idx==DEPTH-1, go to DONE and leave idx unchanged. Otherwise increment idx.
    - With in_valid=0, hold all state. Stalls may last any number of cycles.
  - DONE: done=1, and pass=(err_count==0), both registered. Hold until start or rst.
    - start in DONE → RUN and clears results, exactly as from IDLE.
- start during RUN is ignored.
- in_valid in IDLE or DONE is ignored. Counters do not change.
- Latency:
  - A compare result is visible in err_count on the edge that samples it.
  - done asserts on the edge that samples the last vector.
- Comparison is a full WIDTH-bit equality. 4-state X or Z on dut_out counts as a mismatch, using the case-inequality operator in simulation.
- idx never exceeds DEPTH-1. There is no wrap past the last vector; a new run needs start.
- DEPTH=1: the first valid sample goes straight to DONE.

Optional Feature:
- Macro: GOLDEN_CHECKER_SIG_EN.
- Defined:
  - Adds output sig [15:0], a 16-bit MISR. Polynomial x^16+x^12+x^5+1, seed 16'hFFFF.
  - Reset to the seed on rst and on an accepted start.
  - On each accepted sample, sig is shifted once and XORed with dut_out, zero-extended or truncated to 16 bits.
  - Frozen in DONE.
- Not defined: the sig port and its logic are absent. All other behaviour is identical.

Test Plan:
- Matching run: rst for 2 cycles, start, then 4 valid samples 1,1,1,0 on consecutive cycles → idx steps 0,1,2,3; done=1 and pass=1 on the 4th sample edge; err_count=0.
- Single mismatch: samples 1,0,1,0 → done=1, pass=0, err_count=1, first_err_idx=1.
- Multiple mismatches: samples 0,0,0,1 → err_count=4, first_err_idx=0, pass=0.
- Stalls: samples 1,1,1,0 with in_valid low for 3 cycles between each → idx holds during stalls; same result as the matching run, done after 4 valid samples.
- Mid-run reset and ignored start:
  - After 2 samples, pulse start → ignored, idx stays 2.
  - Then assert rst → all outputs return to reset values, no done.
  - A new start followed by samples 1,1,1,0 gives pass=1.
- Restart and X, run with GOLDEN_CHECKER_SIG_EN defined:
  - From DONE, start and then samples 1,X,1,0 → err_count=1, first_err_idx=1.
  - sig equals the bench model's value computed from the seed, and is restored to 16'hFFFF on the start edge.
